// File: rtl/ddr_frame_arbiter.sv
// Round-robin scheduler sharing one UniPHY Avalon-MM port between a frame write
// stream (write FIFO -> DDR) and a frame read stream (DDR -> read FIFO).
module ddr_frame_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int BURST_LEN   = 4,
  parameter int FRAME_BEATS = 196608,
  parameter int FRAME_BASE  = 0,
  parameter int RD_LIMIT    = 248
) (
  input  logic              afi_clk,
  input  logic              rstn,
  input  logic              local_cal_success,
  input  logic [7:0]        wr_fifo_usedw,
  input  logic [63:0]       wr_fifo_rdata,
  output logic              wr_fifo_rdreq,
  input  logic [7:0]        rd_fifo_usedw,
  output logic [63:0]       rd_fifo_wdata,
  output logic              rd_fifo_wrreq,
  input  logic              avl_ready,
  input  logic              avl_rdata_valid,
  input  logic [63:0]       avl_rdata,
  output logic              avl_burstbegin,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [63:0]       avl_wdata,
  output logic [7:0]        avl_be,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [2:0]        avl_size,
  output logic              frame_wr_done,
  output logic              frame_rd_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ARB, WR_BURST, RD_CMD, RD_WAIT} state_t;

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(FRAME_BEATS - BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(FRAME_BASE);
  localparam logic [2:0]        BEAT_LAST = 3'(BURST_LEN - 1);
  localparam logic [2:0]        SIZE      = 3'(BURST_LEN);
  localparam logic [7:0]        WR_MIN    = 8'(BURST_LEN);
  localparam logic [7:0]        RD_MAX    = 8'(RD_LIMIT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]        beat_q, beat_d;
  logic              last_rd_q, last_rd_d;
  logic              frame_valid_q, frame_valid_d;
  logic [63:0]       rd_wdata_q, rd_wdata_d;
  logic              rd_wrreq_q, rd_wrreq_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_elig, rd_elig;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    beat_d         = beat_q;
    last_rd_d      = last_rd_q;
    frame_valid_d  = frame_valid_q;
    rd_wdata_d     = rd_wdata_q;
    rd_wrreq_d     = 1'b0;
    rd_done_d      = 1'b0;
    wr_fifo_rdreq  = 1'b0;
    avl_burstbegin = 1'b0;
    avl_addr       = '0;
    avl_wdata      = '0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_size       = '0;
    frame_wr_done  = 1'b0;
    wr_elig        = wr_fifo_usedw >= WR_MIN;
    rd_elig        = frame_valid_q && (rd_fifo_usedw <= RD_MAX);

    case (state_q)
      IDLE: begin
        if (local_cal_success) state_d = ARB;
      end
      ARB: begin
        // On a tie, last_rd_q decides: the stream not served last wins.
        if (!local_cal_success) begin
          state_d = IDLE;
        end else if (wr_elig && (!rd_elig || last_rd_q)) begin
          state_d   = WR_BURST;
          last_rd_d = 1'b0;
        end else if (rd_elig) begin
          state_d   = RD_CMD;
          last_rd_d = 1'b1;
        end
      end
      WR_BURST: begin
        avl_write_req  = 1'b1;
        avl_size       = SIZE;
        avl_addr       = BASE + wr_ptr_q;
        avl_wdata      = wr_fifo_rdata;
        avl_burstbegin = (beat_q == 3'd0);
        wr_fifo_rdreq  = avl_ready;
        if (avl_ready) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = 3'd0;
            state_d = ARB;
            if (wr_ptr_q == PTR_LAST) begin
              wr_ptr_d      = '0;
              frame_wr_done = 1'b1;
              frame_valid_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + STEP;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      RD_CMD: begin
        avl_read_req   = 1'b1;
        avl_burstbegin = 1'b1;
        avl_size       = SIZE;
        avl_addr       = BASE + rd_ptr_q;
        if (avl_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avl_rdata_valid) begin
          rd_wrreq_d = 1'b1;
          rd_wdata_d = avl_rdata;
          if (beat_q == BEAT_LAST) begin
            beat_d  = 3'd0;
            state_d = ARB;
            if (rd_ptr_q == PTR_LAST) begin
              rd_ptr_d  = '0;
              rd_done_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + STEP;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      beat_q        <= '0;
      last_rd_q     <= 1'b1;
      frame_valid_q <= 1'b0;
      rd_wdata_q    <= '0;
      rd_wrreq_q    <= 1'b0;
      rd_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_q        <= beat_d;
      last_rd_q     <= last_rd_d;
      frame_valid_q <= frame_valid_d;
      rd_wdata_q    <= rd_wdata_d;
      rd_wrreq_q    <= rd_wrreq_d;
      rd_done_q     <= rd_done_d;
    end
  end

  assign avl_be        = 8'hFF;
  assign rd_fifo_wdata = rd_wdata_q;
  assign rd_fifo_wrreq = rd_wrreq_q;
  assign frame_rd_done = rd_done_q;
  assign busy          = (state_q == WR_BURST) || (state_q == RD_CMD) || (state_q == RD_WAIT);

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Randomized bench for ddr_frame_arbiter: burst-level reference model of grants,
// frame addresses, FIFO pops/pushes and frame-done pulses, checked every cycle.
module tb_ddr_frame_arbiter;

  localparam int AW   = 26;
  localparam int BL   = 4;
  localparam int FB   = 8;
  localparam int BASE = 0;
  localparam int RDL  = 248;

  logic          afi_clk = 1'b0;
  logic          rstn;
  logic          local_cal_success;
  logic [7:0]    wr_fifo_usedw;
  logic [63:0]   wr_fifo_rdata;
  logic          wr_fifo_rdreq;
  logic [7:0]    rd_fifo_usedw;
  logic [63:0]   rd_fifo_wdata;
  logic          rd_fifo_wrreq;
  logic          avl_ready;
  logic          avl_rdata_valid;
  logic [63:0]   avl_rdata;
  logic          avl_burstbegin;
  logic [AW-1:0] avl_addr;
  logic [63:0]   avl_wdata;
  logic [7:0]    avl_be;
  logic          avl_read_req;
  logic          avl_write_req;
  logic [2:0]    avl_size;
  logic          frame_wr_done;
  logic          frame_rd_done;
  logic          busy;

  always #5 afi_clk = ~afi_clk;

  ddr_frame_arbiter #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_BEATS(FB), .FRAME_BASE(BASE), .RD_LIMIT(RDL)
  ) dut (
    .afi_clk(afi_clk), .rstn(rstn), .local_cal_success(local_cal_success),
    .wr_fifo_usedw(wr_fifo_usedw), .wr_fifo_rdata(wr_fifo_rdata), .wr_fifo_rdreq(wr_fifo_rdreq),
    .rd_fifo_usedw(rd_fifo_usedw), .rd_fifo_wdata(rd_fifo_wdata), .rd_fifo_wrreq(rd_fifo_wrreq),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done), .busy(busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          txn_no = 0;
  int unsigned wr_idx = 0;
  int unsigned m_pop = 0;
  int          m_wr_bursts, m_rd_bursts;
  bit          m_fvalid, m_last_rd;
  bit          pend_push, pend_done;
  logic [63:0] pend_data;

  // Show-ahead write FIFO: word i of the stream is a fixed function of i.
  function automatic logic [63:0] wword(input int unsigned i);
    return {32'hC0DE_0000 + i, i * 32'h9E37_79B1};
  endfunction

  assign wr_fifo_rdata = wword(wr_idx);
  always @(posedge afi_clk) if (wr_fifo_rdreq) wr_idx <= wr_idx + 1;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge afi_clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_bursts = 0;
    m_rd_bursts = 0;
    m_fvalid    = 1'b0;
    m_last_rd   = 1'b1;
    pend_push   = 1'b0;
    pend_done   = 1'b0;
    pend_data   = '0;
  endtask

  // Read-FIFO side: whatever valid beat was accepted last cycle shows up now.
  task automatic chk_rd_side();
    expect_eq("rd_wrreq", rd_fifo_wrreq, pend_push);
    if (pend_push) expect_eq("rd_wdata", rd_fifo_wdata, pend_data);
    expect_eq("rd_done", frame_rd_done, pend_done);
    expect_eq("be", avl_be, 8'hFF);
    pend_push = 1'b0;
    pend_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge afi_clk);
    expect_eq({tag, "_rdreq"}, wr_fifo_rdreq, 0);
    expect_eq({tag, "_rdfwd"}, rd_fifo_wdata, 0);
    expect_eq({tag, "_wrreq"}, rd_fifo_wrreq, 0);
    expect_eq({tag, "_bb"}, avl_burstbegin, 0);
    expect_eq({tag, "_addr"}, avl_addr, 0);
    expect_eq({tag, "_wdata"}, avl_wdata, 0);
    expect_eq({tag, "_be"}, avl_be, 8'hFF);
    expect_eq({tag, "_rreq"}, avl_read_req, 0);
    expect_eq({tag, "_wreq"}, avl_write_req, 0);
    expect_eq({tag, "_size"}, avl_size, 0);
    expect_eq({tag, "_wdone"}, frame_wr_done, 0);
    expect_eq({tag, "_rdone"}, frame_rd_done, 0);
    expect_eq({tag, "_busy"}, busy, 0);
  endtask

  task automatic quiet_cycle(input string tag);
    avl_rdata_valid = 1'b0;
    @(negedge afi_clk);
    expect_eq({tag, "_wreq"}, avl_write_req, 0);
    expect_eq({tag, "_rreq"}, avl_read_req, 0);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_rdreq"}, wr_fifo_rdreq, 0);
    chk_rd_side();
    next_cyc();
  endtask

  // Called at the drive point of a cycle in which the DUT is arbitrating.
  task automatic arb_cycle(input logic [7:0] wu, input logic [7:0] ru, output bit gw, output bit gr);
    bit ew, er;
    wr_fifo_usedw   = wu;
    rd_fifo_usedw   = ru;
    avl_ready       = 1'($urandom_range(0, 1));
    avl_rdata_valid = ($urandom_range(0, 7) == 0);
    avl_rdata       = {$urandom, $urandom};
    @(negedge afi_clk);
    expect_eq("arb_wreq", avl_write_req, 0);
    expect_eq("arb_rreq", avl_read_req, 0);
    expect_eq("arb_busy", busy, 0);
    expect_eq("arb_rdreq", wr_fifo_rdreq, 0);
    expect_eq("arb_bb", avl_burstbegin, 0);
    chk_rd_side();
    ew = (int'(wu) >= BL);
    er = m_fvalid && (int'(ru) <= RDL);
    gw = ew && (!er || m_last_rd);
    gr = er && !gw;
    if (gw) m_last_rd = 1'b0;
    else if (gr) m_last_rd = 1'b1;
    next_cyc();
  endtask

  // mode 0: random ready, 1: ready always high, 2: ready low on beats 2-3.
  task automatic serve_write(input int mode);
    int beat = 0;
    int cyc = 0;
    int a;
    bit last_frame;
    a = BASE + (m_wr_bursts * BL) % FB;
    last_frame = (((m_wr_bursts + 1) * BL) % FB) == 0;
    while (beat < BL && cyc < 100) begin
      case (mode)
        1:       avl_ready = 1'b1;
        2:       avl_ready = !(cyc == 1 || cyc == 2);
        default: avl_ready = ($urandom_range(0, 3) != 0);
      endcase
      avl_rdata_valid = ($urandom_range(0, 7) == 0);
      avl_rdata       = {$urandom, $urandom};
      @(negedge afi_clk);
      expect_eq("wr_wreq", avl_write_req, 1);
      expect_eq("wr_rreq", avl_read_req, 0);
      expect_eq("wr_addr", avl_addr, 64'(a));
      expect_eq("wr_size", avl_size, 64'(BL));
      expect_eq("wr_bb", avl_burstbegin, 64'(beat == 0));
      expect_eq("wr_wdata", avl_wdata, wword(m_pop));
      expect_eq("wr_rdreq", wr_fifo_rdreq, avl_ready);
      expect_eq("wr_busy", busy, 1);
      expect_eq("wr_done", frame_wr_done, 64'(avl_ready && beat == BL - 1 && last_frame));
      chk_rd_side();
      if (avl_ready) begin
        beat++;
        m_pop++;
      end
      cyc++;
      next_cyc();
    end
    expect_eq("wr_bound", beat, BL);
    m_wr_bursts++;
    if (last_frame) m_fvalid = 1'b1;
    txn_no++;
    $display("txn %0d WR addr=%0d cycles=%0d frame_end=%0d", txn_no, a, cyc, last_frame);
  endtask

  task automatic serve_read();
    int got = 0;
    int cyc = 0;
    bit acc = 0;
    int a;
    bit last_frame;
    a = BASE + (m_rd_bursts * BL) % FB;
    last_frame = (((m_rd_bursts + 1) * BL) % FB) == 0;
    while (!acc && cyc < 100) begin
      avl_ready       = ($urandom_range(0, 2) != 0);
      avl_rdata_valid = 1'b0;
      @(negedge afi_clk);
      expect_eq("rc_rreq", avl_read_req, 1);
      expect_eq("rc_wreq", avl_write_req, 0);
      expect_eq("rc_bb", avl_burstbegin, 1);
      expect_eq("rc_addr", avl_addr, 64'(a));
      expect_eq("rc_size", avl_size, 64'(BL));
      expect_eq("rc_busy", busy, 1);
      expect_eq("rc_rdreq", wr_fifo_rdreq, 0);
      chk_rd_side();
      acc = avl_ready;
      cyc++;
      next_cyc();
    end
    expect_eq("rc_bound", acc, 1);
    while (got < BL && cyc < 200) begin
      avl_ready       = 1'($urandom_range(0, 1));
      avl_rdata_valid = 1'($urandom_range(0, 1));
      avl_rdata       = {$urandom, $urandom};
      @(negedge afi_clk);
      expect_eq("rw_rreq", avl_read_req, 0);
      expect_eq("rw_wreq", avl_write_req, 0);
      expect_eq("rw_bb", avl_burstbegin, 0);
      expect_eq("rw_busy", busy, 1);
      expect_eq("rw_rdreq", wr_fifo_rdreq, 0);
      chk_rd_side();
      pend_push = avl_rdata_valid;
      pend_data = avl_rdata;
      pend_done = avl_rdata_valid && (got == BL - 1) && last_frame;
      if (avl_rdata_valid) got++;
      cyc++;
      next_cyc();
    end
    expect_eq("rw_bound", got, BL);
    m_rd_bursts++;
    txn_no++;
    $display("txn %0d RD addr=%0d cycles=%0d frame_end=%0d", txn_no, a, cyc, last_frame);
  endtask

  function automatic logic [7:0] pick_wu();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'(BL - 1);
      2:       return 8'(BL);
      3:       return 8'(BL + 1);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [7:0] pick_ru();
    case ($urandom_range(0, 5))
      0:       return 8'(RDL);
      1:       return 8'(RDL + 1);
      2:       return 8'd255;
      3:       return 8'd0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic txn();
    bit gw, gr;
    if ($urandom_range(0, 15) == 0) begin
      local_cal_success = 1'b0;
      wr_fifo_usedw     = 8'd255;
      quiet_cycle("caldrop");
      local_cal_success = 1'b1;
      quiet_cycle("recal");
    end
    arb_cycle(pick_wu(), pick_ru(), gw, gr);
    if (gw) serve_write(0);
    else if (gr) serve_read();
  endtask

  initial begin
    bit gw, gr;
    rstn = 1'b0;
    local_cal_success = 1'b0;
    wr_fifo_usedw = '0;
    rd_fifo_usedw = '0;
    avl_ready = 1'b0;
    avl_rdata_valid = 1'b0;
    avl_rdata = '0;
    model_reset();

    repeat (3) @(posedge afi_clk);
    #1;
    check_reset_outputs("rst");
    next_cyc();

    rstn = 1'b1;
    wr_fifo_usedw = 8'd255;
    repeat (3) quiet_cycle("nocal");
    local_cal_success = 1'b1;
    quiet_cycle("idle2arb");
    repeat (3) arb_cycle(8'd0, 8'd0, gw, gr);

    // Directed opening: plain write, backpressured write closing frame 0, then tie -> read.
    arb_cycle(8'(BL), 8'd0, gw, gr);
    serve_write(1);
    arb_cycle(8'(BL), 8'd0, gw, gr);
    serve_write(2);
    arb_cycle(8'(BL), 8'd0, gw, gr);
    if (gr) serve_read(); else if (gw) serve_write(0);
    arb_cycle(8'(BL), 8'd0, gw, gr);
    if (gw) serve_write(0); else if (gr) serve_read();
    arb_cycle(8'(BL), 8'(RDL + 1), gw, gr);
    if (gw) serve_write(0); else if (gr) serve_read();

    repeat (200) txn();

    // Reset asserted during the second beat of a write burst.
    arb_cycle(8'd200, 8'd255, gw, gr);
    avl_ready = 1'b1;
    avl_rdata_valid = 1'b0;
    @(negedge afi_clk);
    expect_eq("mb_wreq", avl_write_req, 1);
    expect_eq("mb_rdreq", wr_fifo_rdreq, 1);
    m_pop++;
    next_cyc();
    rstn = 1'b0;
    check_reset_outputs("mbrst");
    next_cyc();
    check_reset_outputs("mbhold");
    next_cyc();
    model_reset();
    rstn = 1'b1;
    local_cal_success = 1'b1;
    quiet_cycle("mbidle");
    arb_cycle(8'(BL), 8'd255, gw, gr);
    serve_write(0);

    repeat (40) txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_frame_arbiter.md
# ddr_frame_arbiter

Schedules a single DDR3 UniPHY Avalon-MM port between two video-frame streams. The write stream drains a show-ahead write FIFO into the frame buffer; the read stream refills a read FIFO from the frame buffer. The block sits between the two pixel FIFOs and the UniPHY local interface, and replaces the single-shot write/read test sequencer. It issues fixed-length bursts, grants the two streams round-robin, and walks each stream's frame address with wrap-around.

## Interface
Parameters:
- ADDR_W, 26, Avalon word-address width (one word = 64 bits).
- BURST_LEN, 4, beats per burst, 1..7; FRAME_BEATS must be a multiple of it.
- FRAME_BEATS, 196608, 64-bit words per frame.
- FRAME_BASE, 0, word address of frame start.
- RD_LIMIT, 248, read bursts are allowed only while rd_fifo_usedw <= RD_LIMIT.

Ports (reset rstn, asynchronous, active-low; clock afi_clk):
- afi_clk  in  1  UniPHY user clock.
- rstn  in  1  asynchronous active-low reset.
- local_cal_success  in  1  DDR calibration done.
- wr_fifo_usedw  in  8  write FIFO fill level.
- wr_fifo_rdata  in  64  show-ahead head word of the write FIFO.
- wr_fifo_rdreq  out  1  pops the write FIFO.
- rd_fifo_usedw  in  8  read FIFO fill level.
- rd_fifo_wdata  out  64  word to the read FIFO.
- rd_fifo_wrreq  out  1  pushes to the read FIFO.
- avl_ready  in  1  waitrequest_n.
- avl_rdata_valid  in  1  read data valid.
- avl_rdata  in  64  read data.
- avl_burstbegin  out  1  beginbursttransfer.
- avl_addr  out  ADDR_W  word address.
- avl_wdata  out  64  write data.
- avl_be  out  8  byte enable, constant 8'hFF.
- avl_read_req  out  1  read request.
- avl_write_req  out  1  write request.
- avl_size  out  3  burst count.
- frame_wr_done  out  1  one-cycle pulse when the last write burst of a frame is accepted.
- frame_rd_done  out  1  one-cycle pulse when the last read beat of a frame is pushed.
- busy  out  1  high in any state other than IDLE or ARB.

## Operation
- States: IDLE, ARB, WR_BURST, RD_CMD, RD_WAIT.
- IDLE → ARB when local_cal_success = 1.
- In ARB, the write stream is eligible when wr_fifo_usedw >= BURST_LEN.
- In ARB, the read stream is eligible when frame_valid = 1 and rd_fifo_usedw <= RD_LIMIT.
- frame_valid is an internal flag. It is set when the first frame_wr_done fires and is cleared only by reset.
- When both streams are eligible, grant the one not granted last. last_grant resets to "read", so write wins the first tie.
- ARB with neither stream eligible: stay in ARB.
- ARB with local_cal_success = 0: go to IDLE. A burst already in progress always completes before this check.
- WR_BURST:
  - avl_write_req = 1, avl_size = BURST_LEN, avl_addr = FRAME_BASE + wr_ptr for the whole burst.
  - avl_wdata = wr_fifo_rdata, combinational.
  - wr_fifo_rdreq = avl_write_req & avl_ready.
  - avl_burstbegin is high on the first beat and stays high until that beat is accepted.
  - A beat counter counts accepted beats. After BURST_LEN accepted beats: deassert avl_write_req, advance wr_ptr, go to ARB.
- RD_CMD:
  - avl_read_req = 1, avl_burstbegin = 1, avl_size = BURST_LEN, avl_addr = FRAME_BASE + rd_ptr.
  - Hold these until avl_ready = 1, then deassert and go to RD_WAIT.
- RD_WAIT:
  - Count avl_rdata_valid beats.
  - rd_fifo_wdata/rd_fifo_wrreq are avl_rdata/avl_rdata_valid registered one cycle.
  - After BURST_LEN beats: advance rd_ptr, go to ARB.
- Pointer rules:
  - wr_ptr and rd_ptr step by BURST_LEN.
  - When ptr = FRAME_BEATS − BURST_LEN, the next step wraps to 0 and fires the matching frame_*_done pulse.
  - Pointer arithmetic is ADDR_W wide. FRAME_BASE + FRAME_BEATS must not exceed 2^ADDR_W.
- Reset, including mid-burst: all state returns to IDLE immediately. Pointers, counters, frame_valid and all outputs clear. avl_be = 8'hFF, all other outputs 0.

## Timing
- Cal to first request: ARB is entered one cycle after local_cal_success rises. A request asserts one cycle after an eligible ARB cycle.
- Write burst: BURST_LEN cycles minimum, one extra cycle per avl_ready = 0 cycle. Back-to-back bursts have one ARB cycle between them.
- The write FIFO is not popped while avl_ready = 0.
- Read: rd_fifo_wrreq follows avl_rdata_valid by exactly one cycle. frame_rd_done coincides with the final rd_fifo_wrreq of the frame.
- avl_rdata_valid outside RD_WAIT is ignored. UniPHY never returns data outside RD_WAIT because only one read is ever outstanding.

## Test plan
- Reset hold, then cal: assert local_cal_success with both FIFOs empty → stays in ARB with busy = 0. All outputs at reset values, avl_be = 8'hFF.
- Single write: wr_fifo_usedw = 4, head words 1,2,3,4, avl_ready = 1 → four write beats at avl_addr 0 with wdata 1..4. burstbegin only on beat 1. Exactly 4 rdreq.
- Backpressure: the same write with avl_ready low on beats 2–3 → wdata and address held, no pop while low, burst finishes in 6 cycles.
- Frame wrap with FRAME_BEATS = 8: write 3 bursts → addresses 0, 4, 0. frame_wr_done pulses on the 2nd burst's last beat. Reads become eligible afterwards.
- Round-robin: both streams eligible continuously → order W, R, W, R. RD_WAIT returns 4 beats, rd_fifo_wrreq lags each by 1 cycle. No read while rd_fifo_usedw = 249.
- Reset mid-burst: assert rstn low during beat 2 of a write → all outputs clear immediately. After release and cal, the write restarts at address 0.
